// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl
//   Sequencer for the inverter-chain ring oscillator. A measurement enables
//   the ring, lets it settle for WARMUP_CYC clk cycles, counts synchronised
//   RO rising edges over a window of gate_cycles clk cycles, drops the ring,
//   drains the synchroniser for 3 cycles and then pulses done for one cycle.
//
//   Build option: define RO_AVG4_EN to measure four back-to-back windows and
//   report the truncated average (accumulator >> 2). Undefined gives a single
//   window with no accumulator.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   start        in   1       measurement request, sampled only when idle
//   gate_cycles  in   GATE_W  window length in clk cycles, latched on accept
//   ro_out       in   1       RO tap, asynchronous to clk
//   ro_en        out  1       RO chain enable
//   busy         out  1       high whenever not idle
//   done         out  1       one-cycle pulse, count valid
//   count        out  CNT_W   rising edges in window, held until next accept
//   overflow     out  1       count saturated during last measurement
module ro_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 12,
  parameter int WARMUP_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ro_out,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_MEASURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state, state_n;

  logic              s1, s2, s3;
  logic              ro_rise;
  logic              accept;
  logic [WARM_W-1:0] warm_cnt;
  logic [GATE_W-1:0] gate_lat;
  logic [GATE_W-1:0] gate_cnt;
  logic [1:0]        flush_cnt;
  logic              last_win;
  logic              ro_en_n, busy_n, done_n;
  logic [CNT_W:0]    inc_res;

  // Saturating increment: returns {saturated_hit, next_value}. The hit flag
  // marks an edge that arrived while already at all-ones, i.e. a lost edge.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v,
                                             input logic             inc);
    if (!inc)
      sat_inc = {1'b0, v};
    else if (&v)
      sat_inc = {1'b1, v};
    else
      sat_inc = {1'b0, v + CNT_W'(1)};
  endfunction

  assign accept  = (state == ST_IDLE) && start;
  assign ro_rise = s2 & ~s3;

  // Stage boundary: two-flop synchroniser plus one delay flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ro_out;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (start) state_n = ST_WARMUP;
      ST_WARMUP:  if (warm_cnt == '0)
                    state_n = (gate_lat == '0) ? ST_FLUSH : ST_MEASURE;
      ST_MEASURE: if (gate_cnt == '0 && last_win) state_n = ST_FLUSH;
      ST_FLUSH:   if (flush_cnt == 2'd0) state_n = ST_DONE;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    // Outputs are decoded from the next state and registered so they line
    // up exactly with the state they describe.
    ro_en_n = (state_n == ST_WARMUP) || (state_n == ST_MEASURE);
    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_DONE);
  end

  // Stage boundary: state and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ro_en <= ro_en_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Stage boundary: phase counters. Each counts down to zero on the last
  // cycle of its phase; gate_cnt reloads at every window end so the averaging
  // build can run windows back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt  <= '0;
      gate_lat  <= '0;
      gate_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept) begin
        gate_lat <= gate_cycles;
        warm_cnt <= WARM_LOAD;
      end else if (state == ST_WARMUP) begin
        warm_cnt <= warm_cnt - WARM_W'(1);
      end

      if (state == ST_MEASURE && gate_cnt != '0)
        gate_cnt <= gate_cnt - GATE_W'(1);
      else
        gate_cnt <= gate_lat - GATE_W'(1);

      if (state == ST_FLUSH)
        flush_cnt <= flush_cnt - 2'd1;
      else
        flush_cnt <= 2'd2;
    end
  end

`ifdef RO_AVG4_EN
  localparam int ACC_W = CNT_W + 2;

  logic [1:0]       win_cnt;
  logic [CNT_W-1:0] raw;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign last_win = (win_cnt == 2'd3);
  assign inc_res  = sat_inc(raw, ro_rise);
  // Includes an edge on the window's final cycle.
  assign acc_sum  = acc + ACC_W'(inc_res[CNT_W-1:0]);

  // Stage boundary: per-window raw count, accumulator and averaged result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt  <= '0;
      raw      <= '0;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      win_cnt  <= '0;
      raw      <= '0;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == ST_MEASURE) begin
      if (inc_res[CNT_W])
        overflow <= 1'b1;
      if (gate_cnt == '0) begin
        raw     <= '0;
        acc     <= acc_sum;
        win_cnt <= win_cnt + 2'd1;
        if (last_win)
          count <= CNT_W'(acc_sum >> 2);
      end else begin
        raw <= inc_res[CNT_W-1:0];
      end
    end
  end
`else
  assign last_win = 1'b1;
  assign inc_res  = sat_inc(count, ro_rise);

  // Stage boundary: live saturating edge count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == ST_MEASURE) begin
      count <= inc_res[CNT_W-1:0];
      if (inc_res[CNT_W])
        overflow <= 1'b1;
    end
  end
`endif

endmodule
